reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
//  Parametrised multi-register file: DEPTH words of WIDTH bits, one synchronous
//  write port, two combinational read ports with tri-state output enables.
//  Optional write-through bypass, hardwired-zero register 0, and a background
//  clear sequencer that zeroes the array one word per cycle.
//  Serves as the datapath register bank feeding the A/B operand buses.
// PARAMETERS
//  WIDTH     16  data width in bits
//  DEPTH     8   number of registers, >= 2; ADDR_W = $clog2(DEPTH) (localparam)
//  BYPASS    1   1: a read of the address being written returns wdata this cycle
//  ZERO_REG  0   1: register 0 always reads 0; writes to it are discarded
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  we         in   1       write enable
//  waddr      in   ADDR_W  write address
//  wdata      in   WIDTH   write data
//  raddr_a    in   ADDR_W  read address, port A
//  raddr_b    in   ADDR_W  read address, port B
//  oe_a       in   1       output enable, port A (0 -> da is high-Z)
//  oe_b       in   1       output enable, port B (0 -> db is high-Z)
//  da         out  WIDTH   read data, port A (tri-state)
//  db         out  WIDTH   read data, port B (tri-state)
//  clr_start  in   1       start background clear sweep (1-cycle pulse)
//  clr_busy   out  1       high while the sweep runs
//  wr_drop    out  1       registered 1-cycle pulse: a write was discarded
// BEHAVIOUR
//  Reset: reset=1 asynchronously zeroes all words, FSM -> IDLE, clr_busy=0,
//   wr_drop=0. da/db follow oe_a/oe_b even during reset (read 0 or Z).
//  Write: on rising clk with we=1 and FSM=IDLE, mem[waddr] <= wdata.
//   Discarded (no state change) if waddr >= DEPTH, or waddr==0 with ZERO_REG=1
//   (these two do NOT pulse wr_drop), or FSM=SWEEP (pulses wr_drop next cycle).
//  Read: combinational, zero latency. data = mem[raddr]; 0 if raddr >= DEPTH or
//   (ZERO_REG=1 and raddr==0). Both ports may read same address.
//  Bypass (BYPASS=1): if we=1, FSM=IDLE, write accepted, and raddr==waddr, the
//   port returns wdata in the same cycle. BYPASS=0: old value until next edge.
//  Tri-state: da = oe_a ? data_a : 'z; db = oe_b ? data_b : 'z; independent.
//  Clear FSM, states IDLE, SWEEP; internal pointer ptr (ADDR_W bits):
//   IDLE: clr_start=1 -> SWEEP, ptr<=0, clr_busy<=1 (registered).
//   SWEEP: each edge mem[ptr]<=0, ptr<=ptr+1; on ptr==DEPTH-1 clear it and
//    -> IDLE, clr_busy<=0. Sweep lasts exactly DEPTH cycles; clr_busy high
//    DEPTH cycles starting the edge after clr_start.
//   clr_start during SWEEP ignored (no restart). Reads during SWEEP legal:
//    already-cleared words read 0, others their old value.
//   Simultaneous we and clr_start in IDLE: write commits this edge, sweep
//    starts same edge, so the word is zeroed later in the sweep.
//  Reset mid-sweep: array zeroed, FSM IDLE, ptr=0, clr_busy=0 immediately.
//  No X propagation: uninitialised state impossible after first reset.
// TESTING
//  1 reset, oe_a=oe_b=1, all raddr -> da=db=0; oe_a=0 -> da=Z, db unaffected.
//  2 WIDTH=16,DEPTH=8: write r3=16'hBEEF, r5=16'h1234; raddr_a=3,raddr_b=5 ->
//    da=BEEF, db=1234; raddr_a=raddr_b=3 -> both BEEF.
//  3 BYPASS=1: we=1,waddr=2,wdata=16'hA5A5,raddr_a=2 same cycle -> da=A5A5
//    before edge; BYPASS=0 -> da=old r2 until after edge.
//  4 ZERO_REG=1: write r0=16'hFFFF -> r0 reads 0, wr_drop stays 0.
//  5 fill r0..r7 nonzero, pulse clr_start -> clr_busy high exactly 8 cycles,
//    then all read 0; write during sweep -> discarded, wr_drop 1-cycle pulse.
//  6 assert reset at sweep cycle 3 -> clr_busy=0 at once, all words 0, new
//    clr_start after release runs full 8-cycle sweep.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Register file with one synchronous write port, two combinational tri-state read ports,
// optional write-through bypass, optional hardwired-zero r0 and a background clear sweep.
module reg_file_2r1w #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              oe_a,
  input  logic              oe_b,
  output logic [WIDTH-1:0]  da,
  output logic [WIDTH-1:0]  db,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_drop_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [WIDTH-1:0]  data_a, data_b;

  // Out-of-range and r0 writes vanish silently; only sweep-blocked writes are flagged.
  assign wr_ok = we && (state_q == StIdle) && ({1'b0, waddr} < DepthW) &&
                 !(ZERO_REG && (waddr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastIdx) begin
          state_d = StIdle;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= we && (state_q == StSweep);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[waddr] <= wdata;
      end
      if (state_q == StSweep) begin
        mem[ptr_q] <= '0;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [WIDTH-1:0] rd;
    rd = '0;
    if (({1'b0, ra} < DepthW) && !(ZERO_REG && (ra == '0))) begin
      if (BYPASS && wr_ok && (ra == waddr)) begin
        rd = wdata;
      end else begin
        rd = mem[ra];
      end
    end
    return rd;
  endfunction

  always_comb begin
    data_a = read_port(raddr_a);
    data_b = read_port(raddr_b);
  end

  assign da       = oe_a ? data_a : {WIDTH{1'bz}};
  assign db       = oe_b ? data_b : {WIDTH{1'bz}};
  assign clr_busy = (state_q == StSweep);
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: a bypass instance and a no-bypass/zero-r0 instance share all inputs.
// Read buses are pulled up so a released (high-Z) bus reads as all ones.
module tb_reg_file_2r1w;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a, raddr_b;
  logic        oe_a, oe_b;
  logic        clr_start;
  tri1  [15:0] da, db, da2, db2;
  logic        clr_busy, wr_drop, clr_busy2, wr_drop2;

  int checks = 0;
  int errors = 0;
  int busy_cyc;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .oe_a(oe_a), .oe_b(oe_b),
    .da(da), .db(db), .clr_start(clr_start), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut2 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .oe_a(oe_a), .oe_b(oe_b),
    .da(da2), .db(db2), .clr_start(clr_start), .clr_busy(clr_busy2), .wr_drop(wr_drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, settle, and tally cycles during which the sweep was running.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clr_busy) busy_cyc++;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    oe_a = 1'b1; oe_b = 1'b1; clr_start = 1'b0; busy_cyc = 0;
    #1 reset = 1'b1;
    #1;
    // Reset state: everything reads zero, tri-state follows oe even in reset.
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i);
      #1;
      chk("rst_da", da, 16'h0000);
      chk("rst_db", db, 16'h0000);
    end
    chk("rst_busy", {15'b0, clr_busy}, 16'h0000);
    chk("rst_drop", {15'b0, wr_drop}, 16'h0000);
    oe_a = 1'b0;
    #1;
    chk("oe_a_off_da", da, 16'hFFFF);
    chk("oe_a_off_db", db, 16'h0000);
    oe_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Basic writes and dual reads.
    wr(3'd3, 16'hBEEF);
    wr(3'd5, 16'h1234);
    raddr_a = 3'd3; raddr_b = 3'd5;
    #1;
    chk("rd_a_r3", da, 16'hBEEF);
    chk("rd_b_r5", db, 16'h1234);
    chk("rd2_a_r3", da2, 16'hBEEF);
    raddr_b = 3'd3;
    #1;
    chk("same_a", da, 16'hBEEF);
    chk("same_b", db, 16'hBEEF);
    oe_b = 1'b0;
    #1;
    chk("oe_b_off_db", db, 16'hFFFF);
    chk("oe_b_off_da", da, 16'hBEEF);
    oe_b = 1'b1;

    // Bypass vs. no bypass on r2 (currently 0).
    we = 1'b1; waddr = 3'd2; wdata = 16'hA5A5; raddr_a = 3'd2;
    #1;
    chk("bypass_da", da, 16'hA5A5);
    chk("nobypass_da2", da2, 16'h0000);
    tick();
    we = 1'b0;
    #1;
    chk("after_edge_da2", da2, 16'hA5A5);

    // Zero register: dut2 discards r0 writes without flagging, dut stores them.
    wr(3'd0, 16'hFFFF);
    raddr_a = 3'd0;
    #1;
    chk("zr_da2", da2, 16'h0000);
    chk("zr_drop2", {15'b0, wr_drop2}, 16'h0000);
    chk("r0_da", da, 16'hFFFF);

    // Fill all words, then sweep.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1100 + 16'(i));
    raddr_a = 3'd6; raddr_b = 3'd7;
    #1;
    chk("fill_r6", da, 16'h1106);
    chk("fill_r7", db, 16'h1107);
    busy_cyc = 0;
    pulse_clr();
    chk("busy_start", {15'b0, clr_busy}, 16'h0001);
    tick();
    tick();
    // Two words cleared so far.
    raddr_a = 3'd1; raddr_b = 3'd5;
    #1;
    chk("mid_r1", da, 16'h0000);
    chk("mid_r5", db, 16'h1105);
    we = 1'b1; waddr = 3'd6; wdata = 16'hDEAD;
    tick();
    we = 1'b0;
    chk("drop_pulse", {15'b0, wr_drop}, 16'h0001);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("drop_end", {15'b0, wr_drop}, 16'h0000);
    for (int i = 0; i < 20 && clr_busy; i++) tick();
    chk("busy_len", 16'(busy_cyc), 16'd8);
    chk("busy_done", {15'b0, clr_busy}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      chk("swept", da, 16'h0000);
    end

    // Reset in the middle of a sweep.
    for (int i = 1; i < 8; i++) wr(3'(i), 16'h2200 + 16'(i));
    busy_cyc = 0;
    pulse_clr();
    tick();
    tick();
    raddr_b = 3'd5;
    #1;
    chk("pre_rst_r5", db, 16'h2205);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {15'b0, clr_busy}, 16'h0000);
    chk("rst_mid_r5", db, 16'h0000);
    raddr_a = 3'd7;
    #1;
    chk("rst_mid_r7", da, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wr(3'd4, 16'h4444);
    busy_cyc = 0;
    pulse_clr();
    for (int i = 0; i < 20 && clr_busy; i++) tick();
    chk("resweep_len", 16'(busy_cyc), 16'd8);
    raddr_a = 3'd4;
    #1;
    chk("resweep_r4", da, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
